// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB transmit-path types and constants
//
// Purpose: common definitions for the USB transmit serial path.
//   USB_STUFF_LEN : number of consecutive 1s that forces a stuffed 0.
//   bs_state_t    : bit-stuffer state encoding.
package usb_pkg;

  localparam int USB_STUFF_LEN = 6;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_SEND,
    BS_STUFF
  } bs_state_t;

endpackage

// File: rtl/bit_stuff_encode.sv
// rtl/bit_stuff_encode.sv - USB transmit bit stuffer
//
// Purpose: inserts a 0 after every STUFF_LEN consecutive 1s in the serial
// packet+CRC stream. It stalls the upstream stage for each inserted bit.
//
// Ports:
//   clock     in   system clock, all flops on posedge
//   reset_n   in   asynchronous active-low reset
//   in_bit    in   serial bit from the CRC encoder
//   in_valid  in   in_bit valid; high for the whole packet
//   bs_ready  out  stuffer accepts in_bit this cycle (low while stuffing)
//   out_bit   out  stuffed serial bit to the NRZI encoder (registered)
//   out_valid out  out_bit valid (registered)
//   out_eop   out  one-cycle pulse after the final out_valid of a packet
module bit_stuff_encode
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_bit,
  input  logic in_valid,
  output logic bs_ready,
  output logic out_bit,
  output logic out_valid,
  output logic out_eop
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(STUFF_LEN - 1);
  localparam logic [CW-1:0] RUN_FULL = CW'(STUFF_LEN);

  bs_state_t     state_q, state_d;
  logic [CW-1:0] ones_cnt_q, ones_cnt_d;
  logic          out_bit_q, out_bit_d;
  logic          out_valid_q, out_valid_d;
  logic          out_eop_q, out_eop_d;

  // Decoded from state alone so upstream sees no path from in_valid.
  assign bs_ready  = (state_q != BS_STUFF);
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_eop   = out_eop_q;

  always_comb begin
    state_d     = state_q;
    ones_cnt_d  = ones_cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    out_eop_d   = 1'b0;

    case (state_q)
      BS_IDLE, BS_SEND: begin
        if (in_valid) begin
          out_bit_d   = in_bit;
          out_valid_d = 1'b1;
          if (in_bit) begin
            if (ones_cnt_q == RUN_LAST) begin
              ones_cnt_d = RUN_FULL;
              state_d    = BS_STUFF;
            end else begin
              ones_cnt_d = ones_cnt_q + CW'(1);
              state_d    = BS_SEND;
            end
          end else begin
            ones_cnt_d = '0;
            state_d    = BS_SEND;
          end
        end else if (state_q == BS_SEND) begin
          // End of packet: close it out and drop any pending run.
          out_eop_d  = 1'b1;
          ones_cnt_d = '0;
          state_d    = BS_IDLE;
        end
      end

      BS_STUFF: begin
        // Upstream is held off this cycle; in_bit/in_valid are ignored.
        out_bit_d   = 1'b0;
        out_valid_d = 1'b1;
        ones_cnt_d  = '0;
        state_d     = BS_SEND;
      end

      default: begin
        state_d    = BS_IDLE;
        ones_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BS_IDLE;
      ones_cnt_q  <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_eop_q   <= out_eop_d;
    end
  end

endmodule

// File: tb/tb_bit_stuff_encode.sv
// tb/tb_bit_stuff_encode.sv - scoreboard bench for bit_stuff_encode
module tb_bit_stuff_encode;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic bs_ready, out_bit, out_valid, out_eop;

  int total = 0;
  int bad = 0;
  int stalls = 0;
  int exp_q[$];      // 0/1 = expected bit, 2 = expected eop pulse
  logic prev_valid = 1'b0;

  bit_stuff_encode #(.STUFF_LEN(6)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .bs_ready (bs_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_eop  (out_eop)
  );

  always #5 clock = ~clock;

  // Monitor: compares DUT output against the scoreboard queue on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid || out_eop) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got valid=%0b eop=%0b bit=%0b, required nothing",
                   out_valid, out_eop, out_bit);
        end else begin
          int e;
          int got;
          e = exp_q.pop_front();
          got = out_eop ? 2 : int'(out_bit);
          if (out_valid && out_eop) got = 3;
          if (got != e) begin
            bad++;
            $display("FAIL stream_item: got %0d, required %0d", got, e);
          end
        end
      end else if (prev_valid) begin
        total++;
        bad++;
        $display("FAIL eop_follow: got out_eop=0 after last valid, required 1");
      end
      prev_valid = out_valid;
      if (!bs_ready) stalls++;
    end
  end

  task automatic push_expected(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back((s[i] == "1") ? 1 : 0);
    exp_q.push_back(2);
  endtask

  // Drives each bit and holds it until accepted (bs_ready sampled before the edge).
  task automatic send_bits(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic acc;
      int guard;
      in_valid = 1'b1;
      in_bit = (s[i] == "1");
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 10) begin
        @(negedge clock);
        acc = bs_ready;
        @(posedge clock);
        #1;
        guard++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no accept, required accept of bit %0d", i);
      end
    end
  endtask

  task automatic run_packet(input string name, input string in_s,
                            input string out_s, input int exp_stalls);
    stalls = 0;
    push_expected(out_s);
    send_bits(in_s);
    in_valid = 1'b0;
    in_bit = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d items left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (stalls != exp_stalls) begin
      bad++;
      $display("FAIL %s_stalls: got %0d, required %0d", name, stalls, exp_stalls);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  initial begin
    #12;
    check1("rst_ready", bs_ready, 1'b1);
    check1("rst_valid", out_valid, 1'b0);
    check1("rst_eop", out_eop, 1'b0);
    check1("rst_bit", out_bit, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_packet("t1_plain", "01010011", "01010011", 0);
    run_packet("t2_one_stuff", "11111100", "111111000", 1);
    run_packet("t3_two_stuff", "111111111111", "11111101111110", 2);
    run_packet("t4_end_stuff", "00111111", "001111110", 1);
    run_packet("t5a_five", "11111", "11111", 0);
    run_packet("t5b_three", "111", "111", 0);
    run_packet("t5c_run_0", "0111111", "01111110", 1);

    // Reset while the stuffed 0 is pending.
    stalls = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(1);
    send_bits("111111");
    in_valid = 1'b0;
    check1("t6_in_stuff", bs_ready, 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check1("t6_rst_valid", out_valid, 1'b0);
    check1("t6_rst_eop", out_eop, 1'b0);
    check1("t6_rst_ready", bs_ready, 1'b1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL t6_pre_drain: got %0d items left, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0 || out_valid || out_eop) begin
      bad++;
      $display("FAIL t6_quiet: got valid=%0b eop=%0b, required 0 0", out_valid, out_eop);
    end
    run_packet("t6_after", "11111111", "111111011", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
